// File: rtl/axistream_packet_arbiter.sv
// Round-robin, packet-locked AXI-Stream arbiter: one grant is held until that
// source's tlast beat is accepted, and a single registered stage drives dest_*.
module axistream_packet_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SRC    = 4,
    localparam int ID_WIDTH  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC-1:0]            src_tvalid,
    output logic [NUM_SRC-1:0]            src_tready,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_tdata,
    input  logic [NUM_SRC-1:0]            src_tlast,
    output logic                          dest_tvalid,
    input  logic                          dest_tready,
    output logic [DATA_WIDTH-1:0]         dest_tdata,
    output logic                          dest_tlast,
    output logic [ID_WIDTH-1:0]           dest_tid,
    output logic                          busy
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [ID_WIDTH-1:0]   grant_q, grant_d;
    logic [ID_WIDTH-1:0]   last_grant_q, last_grant_d;
    logic                  dest_tvalid_q, dest_tvalid_d;
    logic [DATA_WIDTH-1:0] dest_tdata_q, dest_tdata_d;
    logic                  dest_tlast_q, dest_tlast_d;
    logic [ID_WIDTH-1:0]   dest_tid_q, dest_tid_d;

    logic [ID_WIDTH-1:0]   winner;
    logic                  any_valid;
    int                    arb_dist;
    int                    arb_best;

    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  out_free;
    logic                  accept;

    // Winner is the valid source at the smallest rotational distance past last_grant.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        winner    = '0;
        any_valid = |src_tvalid;
        arb_dist  = 0;
        arb_best  = NUM_SRC;
        for (int i = 0; i < NUM_SRC; i++) begin
            arb_dist = (i + NUM_SRC - 1 - int'(last_grant_q)) % NUM_SRC;
            if (src_tvalid[i] && (arb_dist < arb_best)) begin
                arb_best = arb_dist;
                winner   = ID_WIDTH'(i);
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q == ID_WIDTH'(i)) begin
                sel_valid = src_tvalid[i];
                sel_last  = src_tlast[i];
                sel_data  = src_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign out_free = !dest_tvalid_q || dest_tready;
    assign accept   = (state_q == ST_LOCKED) && sel_valid && out_free;

    // Ready is forced low while reset is asserted, independent of the flops.
    always_comb begin
        src_tready = '0;
        if (rst_n && (state_q == ST_LOCKED)) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (grant_q == ID_WIDTH'(i)) begin
                    src_tready[i] = out_free;
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (any_valid) begin
                    grant_d = winner;
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                if (accept && sel_last) begin
                    state_d      = ST_IDLE;
                    last_grant_d = grant_q;
                end
            end
        endcase
    end

    // A load wins over a drain, so a same-cycle load/drain keeps dest_tvalid high.
    always_comb begin
        dest_tvalid_d = dest_tvalid_q;
        dest_tdata_d  = dest_tdata_q;
        dest_tlast_d  = dest_tlast_q;
        dest_tid_d    = dest_tid_q;
        if (accept) begin
            dest_tvalid_d = 1'b1;
            dest_tdata_d  = sel_data;
            dest_tlast_d  = sel_last;
            dest_tid_d    = grant_q;
        end else if (dest_tvalid_q && dest_tready) begin
            dest_tvalid_d = 1'b0;
        end
    end

    // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            last_grant_q  <= ID_WIDTH'(NUM_SRC - 1);
            dest_tvalid_q <= 1'b0;
            dest_tdata_q  <= '0;
            dest_tlast_q  <= 1'b0;
            dest_tid_q    <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            dest_tvalid_q <= dest_tvalid_d;
            dest_tdata_q  <= dest_tdata_d;
            dest_tlast_q  <= dest_tlast_d;
            dest_tid_q    <= dest_tid_d;
        end
    end

    assign dest_tvalid = dest_tvalid_q;
    assign dest_tdata  = dest_tdata_q;
    assign dest_tlast  = dest_tlast_q;
    assign dest_tid    = dest_tid_q;
    assign busy        = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_axistream_packet_arbiter.sv
// Self-checking bench: per-cycle vector table, then contention, random
// backpressure with a per-source scoreboard, and reset in the middle of a packet.
module tb_axistream_packet_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   src_tvalid;
    logic [3:0]   src_tready;
    logic [127:0] src_tdata;
    logic [3:0]   src_tlast;
    logic         dest_tvalid;
    logic         dest_tready;
    logic [31:0]  dest_tdata;
    logic         dest_tlast;
    logic [1:0]   dest_tid;
    logic         busy;

    axistream_packet_arbiter #(.DATA_WIDTH(32), .NUM_SRC(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .src_tvalid  (src_tvalid),
        .src_tready  (src_tready),
        .src_tdata   (src_tdata),
        .src_tlast   (src_tlast),
        .dest_tvalid (dest_tvalid),
        .dest_tready (dest_tready),
        .dest_tdata  (dest_tdata),
        .dest_tlast  (dest_tlast),
        .dest_tid    (dest_tid),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Source i drives {i, data} so the producing source is visible in every beat.
    task automatic set_data(input logic [23:0] data);
        for (int i = 0; i < 4; i++) src_tdata[i*32 +: 32] = {8'(i), data};
    endtask

    typedef struct {
        logic        rst_n;
        logic [3:0]  vld;
        logic [3:0]  lst;
        logic [23:0] data;
        logic        rdy;
        logic [3:0]  e_rdy;
        logic        e_dv;
        logic        e_last;
        logic [1:0]  e_tid;
        logic        e_busy;
        logic [31:0] e_data;
    } vec_t;

    localparam int NVEC = 24;
    vec_t vecs[NVEC];

    // Traffic model state
    typedef logic [32:0] beat_q_t[$];
    beat_q_t     sb_q[4];
    int          pkts_left[4];
    int          len[4];
    int          beat[4];
    logic [23:0] seq[4];
    logic [1:0]  out_tids[$];
    int          last_in_cyc;
    int          first_out_cyc;

    function automatic int new_len(input bit fixed_len);
        return fixed_len ? 2 : int'($urandom_range(1, 8));
    endfunction

    function automatic bit traffic_done();
        bit done = 1'b1;
        for (int i = 0; i < 4; i++) if (pkts_left[i] != 0 || sb_q[i].size() != 0) done = 1'b0;
        return done;
    endfunction

    task automatic init_sources(input int npkts, input bit fixed_len);
        for (int i = 0; i < 4; i++) begin
            pkts_left[i] = npkts;
            len[i]       = new_len(fixed_len);
            beat[i]      = 0;
            seq[i]       = 24'(i * 4096);
            sb_q[i].delete();
        end
        out_tids.delete();
        last_in_cyc   = -1;
        first_out_cyc = -1;
    endtask

    // Called at a negedge; drives one cycle per iteration and samples 1ns later.
    task automatic run_traffic(input int budget, input bit fixed_len);
        int          cyc = 0;
        bit          prev_stall = 1'b0;
        logic        prev_last = 1'b0;
        logic [1:0]  prev_tid = '0;
        logic [31:0] prev_data = '0;
        bit          in_pkt = 1'b0;
        logic [1:0]  cur_tid = '0;
        while (!traffic_done() && cyc < budget) begin
            for (int i = 0; i < 4; i++) begin
                src_tvalid[i]          = (pkts_left[i] > 0);
                src_tlast[i]           = (beat[i] == len[i] - 1);
                src_tdata[i*32 +: 32]  = {8'(i), seq[i]};
            end
            dest_tready = fixed_len ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            check("ready_onehot", 64'($countones(src_tready) <= 1), 1);
            if (prev_stall)
                check("stall_hold", {dest_tvalid, dest_tlast, dest_tid, dest_tdata},
                      {1'b1, prev_last, prev_tid, prev_data});
            prev_stall = dest_tvalid && !dest_tready;
            prev_last  = dest_tlast;
            prev_tid   = dest_tid;
            prev_data  = dest_tdata;
            for (int i = 0; i < 4; i++) begin
                if (src_tvalid[i] && src_tready[i]) begin
                    sb_q[i].push_back({src_tlast[i], src_tdata[i*32 +: 32]});
                    seq[i]++;
                    last_in_cyc = cyc;
                    if (src_tlast[i]) begin
                        pkts_left[i]--;
                        beat[i] = 0;
                        len[i]  = new_len(fixed_len);
                    end else begin
                        beat[i]++;
                    end
                end
            end
            if (dest_tvalid && dest_tready) begin
                if (first_out_cyc < 0) first_out_cyc = cyc;
                out_tids.push_back(dest_tid);
                if (in_pkt) check("no_interleave", dest_tid, cur_tid);
                in_pkt  = !dest_tlast;
                cur_tid = dest_tid;
                check("sb_nonempty", 64'(sb_q[dest_tid].size() != 0), 1);
                if (sb_q[dest_tid].size() != 0)
                    check("sb_beat", {dest_tlast, dest_tdata}, sb_q[dest_tid].pop_front());
            end
            @(negedge clk);
            cyc++;
        end
        check("traffic_complete", 64'(traffic_done()), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        //          rst  vld    lst    data       rdy | e_rdy  dv    last  tid    busy  e_data
        vecs[0]  = '{1'b0, 4'hF, 4'h0, 24'h0000,  1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 4'hF, 4'hF, 24'h0000,  1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 4'h4, 4'h0, 24'h00A1,  1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 4'h4, 4'h0, 24'h00A1,  1'b1, 4'h4, 1'b0, 1'b0, 2'd0, 1'b1, 32'h0};
        vecs[4]  = '{1'b1, 4'h4, 4'h0, 24'h00A2,  1'b1, 4'h4, 1'b1, 1'b0, 2'd2, 1'b1, 32'h020000A1};
        vecs[5]  = '{1'b1, 4'h4, 4'h4, 24'h00A3,  1'b1, 4'h4, 1'b1, 1'b0, 2'd2, 1'b1, 32'h020000A2};
        vecs[6]  = '{1'b1, 4'h0, 4'h0, 24'h0000,  1'b1, 4'h0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h020000A3};
        vecs[7]  = '{1'b1, 4'h9, 4'h0, 24'h0000,  1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 4'h9, 4'h8, 24'h00B1,  1'b1, 4'h8, 1'b0, 1'b0, 2'd0, 1'b1, 32'h0};
        vecs[9]  = '{1'b1, 4'h9, 4'h9, 24'h00B2,  1'b1, 4'h0, 1'b1, 1'b1, 2'd3, 1'b0, 32'h030000B1};
        vecs[10] = '{1'b1, 4'h9, 4'h9, 24'h00B3,  1'b1, 4'h1, 1'b0, 1'b0, 2'd0, 1'b1, 32'h0};
        vecs[11] = '{1'b1, 4'h3, 4'h3, 24'h00C1,  1'b1, 4'h0, 1'b1, 1'b1, 2'd0, 1'b0, 32'h000000B3};
        vecs[12] = '{1'b1, 4'h3, 4'h3, 24'h00C2,  1'b1, 4'h2, 1'b0, 1'b0, 2'd0, 1'b1, 32'h0};
        vecs[13] = '{1'b1, 4'h3, 4'h3, 24'h00C3,  1'b1, 4'h0, 1'b1, 1'b1, 2'd1, 1'b0, 32'h010000C2};
        vecs[14] = '{1'b1, 4'h3, 4'h3, 24'h00C4,  1'b1, 4'h1, 1'b0, 1'b0, 2'd0, 1'b1, 32'h0};
        vecs[15] = '{1'b1, 4'h0, 4'h0, 24'h0000,  1'b1, 4'h0, 1'b1, 1'b1, 2'd0, 1'b0, 32'h000000C4};
        vecs[16] = '{1'b1, 4'h2, 4'h0, 24'h00D1,  1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0};
        vecs[17] = '{1'b1, 4'h2, 4'h0, 24'h00D1,  1'b0, 4'h2, 1'b0, 1'b0, 2'd0, 1'b1, 32'h0};
        vecs[18] = '{1'b1, 4'h2, 4'h0, 24'h00D2,  1'b0, 4'h0, 1'b1, 1'b0, 2'd1, 1'b1, 32'h010000D1};
        vecs[19] = '{1'b1, 4'h2, 4'h0, 24'h00D2,  1'b0, 4'h0, 1'b1, 1'b0, 2'd1, 1'b1, 32'h010000D1};
        vecs[20] = '{1'b1, 4'h2, 4'h2, 24'h00D2,  1'b1, 4'h2, 1'b1, 1'b0, 2'd1, 1'b1, 32'h010000D1};
        vecs[21] = '{1'b1, 4'h0, 4'h0, 24'h0000,  1'b0, 4'h0, 1'b1, 1'b1, 2'd1, 1'b0, 32'h010000D2};
        vecs[22] = '{1'b1, 4'h0, 4'h0, 24'h0000,  1'b1, 4'h0, 1'b1, 1'b1, 2'd1, 1'b0, 32'h010000D2};
        vecs[23] = '{1'b1, 4'h0, 4'h0, 24'h0000,  1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0};

        rst_n       = 1'b0;
        src_tvalid  = '0;
        src_tlast   = '0;
        src_tdata   = '0;
        dest_tready = 1'b1;

        // Per-cycle vectors: reset, single source, wrap, alternation, backpressure
        for (int v = 0; v < NVEC; v++) begin
            @(negedge clk);
            rst_n       = vecs[v].rst_n;
            src_tvalid  = vecs[v].vld;
            src_tlast   = vecs[v].lst;
            dest_tready = vecs[v].rdy;
            set_data(vecs[v].data);
            #1;
            check($sformatf("v%0d src_tready", v), src_tready, vecs[v].e_rdy);
            check($sformatf("v%0d dest_tvalid", v), dest_tvalid, vecs[v].e_dv);
            check($sformatf("v%0d busy", v), busy, vecs[v].e_busy);
            if (vecs[v].e_dv || !vecs[v].rst_n) begin
                check($sformatf("v%0d dest_tdata", v), dest_tdata, vecs[v].e_data);
                check($sformatf("v%0d dest_tlast", v), dest_tlast, vecs[v].e_last);
                check($sformatf("v%0d dest_tid", v), dest_tid, vecs[v].e_tid);
            end
        end

        // All four sources contend with 2-beat packets straight out of reset
        @(negedge clk);
        rst_n      = 1'b0;
        src_tvalid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        init_sources(1, 1'b1);
        run_traffic(200, 1'b1);
        check("contention_input_cycles", 64'(last_in_cyc + 1), 12);
        check("contention_first_out_cycle", 64'(first_out_cyc), 2);
        check("contention_out_count", 64'(out_tids.size()), 8);
        for (int k = 0; k < out_tids.size() && k < 8; k++)
            check($sformatf("contention_order_%0d", k), out_tids[k], 64'(k / 2));

        // Random packet lengths under 50% downstream backpressure
        init_sources(6, 1'b0);
        run_traffic(3000, 1'b0);

        // Prime last_grant=1 with a single-beat packet from source 1
        src_tvalid  = 4'b0010;
        src_tlast   = 4'b0010;
        dest_tready = 1'b1;
        set_data(24'h00E0);
        @(negedge clk);
        #1 check("prime_ready", src_tready, 4'b0010);
        @(negedge clk);
        #1 check("prime_out", {dest_tvalid, dest_tlast, dest_tid, dest_tdata}, {1'b1, 1'b1, 2'd1, 32'h010000E0});
        // Start a 4-beat packet from source 1 and reset it on beat 2
        src_tlast = 4'b0000;
        set_data(24'h00E1);
        @(negedge clk);
        #1 check("midrst_ready_beat1", src_tready, 4'b0010);
        @(negedge clk);
        set_data(24'h00E2);
        #1 check("midrst_out_beat1", {dest_tvalid, dest_tdata}, {1'b1, 32'h010000E1});
        #1 rst_n = 1'b0;
        #1;
        check("midrst_async_tvalid", dest_tvalid, 0);
        check("midrst_async_tdata", dest_tdata, 0);
        check("midrst_async_tid", dest_tid, 0);
        check("midrst_async_busy", busy, 0);
        check("midrst_async_ready", src_tready, 0);
        @(negedge clk);
        rst_n      = 1'b1;
        src_tvalid = 4'b0110;
        src_tlast  = 4'b0110;
        set_data(24'h00E3);
        #1 check("postrst_idle", {src_tready, busy}, {4'b0000, 1'b0});
        @(negedge clk);
        #1 check("postrst_lowest_grant", src_tready, 4'b0010);
        @(negedge clk);
        src_tvalid = '0;
        src_tlast  = '0;
        #1 check("postrst_out", {dest_tvalid, dest_tlast, dest_tid, dest_tdata}, {1'b1, 1'b1, 2'd1, 32'h010000E3});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
